button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/button_conditioner.sv | 122 ++++++++++++
 tb/tb_button_conditioner.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_pkg;

    localparam int CNT_W                 = 32;
    localparam int DEF_DEBOUNCE_CYCLES   = 1000000;
    localparam int DEF_REPEAT_DELAY      = 25000000;
    localparam int DEF_REPEAT_PERIOD     = 15000000;
    localparam int DEF_REPEAT_EN         = 1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    // Saturating increment: a long hold must never alias back to a small count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces an active-low push-button and produces press/release/auto-repeat
// strobes plus a wrapping press counter.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       botao,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             botao_s;
    logic             act;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             press_n, release_n, repeat_n;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (botao),
        .q       (botao_s)
    );

    assign act = ~botao_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            repeat_pulse  <= repeat_n;
            if (press_n)
                press_count <= press_count + 8'd1;
        end
    end

    // Strobes are registered on the transition edge, so each lands in the
    // first cycle of the state it announces.
    always_comb begin
        state_n   = state;
        cnt_n     = sat_inc(cnt);
        press_n   = 1'b0;
        release_n = 1'b0;
        repeat_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (act)
                    state_n = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!act) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end
            end
            HELD: begin
                if (!act) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end else if (REPEAT_EN != 0 && cnt == DLY_LAST) begin
                    state_n  = REPEAT;
                    cnt_n    = '0;
                    repeat_n = 1'b1;
                end
            end
            REPEAT: begin
                if (!act) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end else if (cnt == PER_LAST) begin
                    cnt_n    = '0;
                    repeat_n = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to active resumes the hold without a new press.
                if (act) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign pressed = (state == HELD) || (state == REPEAT) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       botao = 1'b1;
    logic       botao2 = 1'b1;
    logic       pressed, press_pulse, release_pulse, repeat_pulse;
    logic [7:0] press_count;
    logic       pressed2, press_pulse2, release_pulse2, repeat_pulse2;
    logic [7:0] press_count2;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .REPEAT_EN(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .botao(botao),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .press_count(press_count)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .REPEAT_EN(0)
    ) dut_norpt (
        .clock(clock), .reset_n(reset_n), .botao(botao2),
        .pressed(pressed2), .press_pulse(press_pulse2), .release_pulse(release_pulse2),
        .repeat_pulse(repeat_pulse2), .press_count(press_count2)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_press = 0, n_rel = 0, n_rpt = 0, t_press = 0, t_rel = 0;
    int n_press2 = 0, n_rel2 = 0, n_rpt2 = 0;
    int rpt_q[$];
    bit pressed_seen = 0, unpressed_seen = 0;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (press_pulse)   begin n_press++; t_press = cyc; end
            if (release_pulse) begin n_rel++;   t_rel = cyc;   end
            if (repeat_pulse)  begin n_rpt++;   rpt_q.push_back(cyc); end
            if (pressed)  pressed_seen = 1;
            if (!pressed) unpressed_seen = 1;
            if (press_pulse2)   n_press2++;
            if (release_pulse2) n_rel2++;
            if (repeat_pulse2)  n_rpt2++;
            checks++;
            if ((int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse)) > 1) begin
                errors++;
                $display("FAIL exclusive_pulses @%0d: got press=%b rel=%b rpt=%b expected at most one",
                         cyc, press_pulse, release_pulse, repeat_pulse);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({pressed, press_pulse, release_pulse, repeat_pulse, press_count} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pressed, press_pulse, release_pulse, repeat_pulse, press_count});
        end
        checks++;
        if ({pressed2, press_pulse2, release_pulse2, repeat_pulse2, press_count2} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs_norpt: got %h expected 0",
                     {pressed2, press_pulse2, release_pulse2, repeat_pulse2, press_count2});
        end
        reset_n = 1'b1;
        tick(4);
        checks++;
        if (pressed !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got pressed=%b count=%0d expected 0/0", pressed, press_count);
        end
    endtask

    task automatic test_bounce_press();
        int np, nr, nt;
        np = n_press; nr = n_rel; nt = n_rpt;
        pressed_seen = 0;
        repeat (5) begin
            botao = 1'b0; tick(2);
            botao = 1'b1; tick(2);
        end
        tick(10);
        checks++;
        if ((n_press - np) + (n_rel - nr) + (n_rpt - nt) != 0) begin
            errors++;
            $display("FAIL bounce_press_pulses: got %0d expected 0", (n_press - np) + (n_rel - nr) + (n_rpt - nt));
        end
        checks++;
        if (pressed_seen) begin
            errors++;
            $display("FAIL bounce_press_pressed: got 1 expected 0");
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL bounce_press_count: got %0d expected 0", press_count);
        end
    endtask

    task automatic test_clean_press();
        int c0, c1, np, nr;
        np = n_press; nr = n_rel;
        rpt_q.delete();
        c0 = cyc;
        botao = 1'b0;
        tick(10);
        checks++;
        if (pressed !== 1'b1) begin
            errors++;
            $display("FAIL clean_pressed_level: got %b expected 1", pressed);
        end
        tick(20);
        c1 = cyc;
        botao = 1'b1;
        tick(12);
        checks++;
        if (n_press - np != 1 || t_press != c0 + 7) begin
            errors++;
            $display("FAIL clean_press_latency: got n=%0d at %0d expected n=1 at %0d", n_press - np, t_press, c0 + 7);
        end
        checks++;
        if (rpt_q.size() < 3 || rpt_q[0] != c0 + 17 || rpt_q[1] != c0 + 22 || rpt_q[2] != c0 + 27) begin
            errors++;
            $display("FAIL clean_repeat_times: got n=%0d first=%0d expected %0d,%0d,%0d",
                     rpt_q.size(), (rpt_q.size() > 0) ? rpt_q[0] : -1, c0 + 17, c0 + 22, c0 + 27);
        end
        checks++;
        if (n_rel - nr != 1 || t_rel != c1 + 7) begin
            errors++;
            $display("FAIL clean_release: got n=%0d at %0d expected n=1 at %0d", n_rel - nr, t_rel, c1 + 7);
        end
        checks++;
        if (press_count !== 8'd1 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL clean_final: got count=%0d pressed=%b expected 1/0", press_count, pressed);
        end
    endtask

    task automatic test_bounce_release();
        int cg, np, nr;
        botao = 1'b0;
        tick(10);
        np = n_press; nr = n_rel;
        rpt_q.delete();
        unpressed_seen = 0;
        cg = cyc;
        botao = 1'b1; tick(2);
        botao = 1'b0; tick(20);
        checks++;
        if (n_rel != nr || n_press != np) begin
            errors++;
            $display("FAIL glitch_no_pulses: got rel=%0d press=%0d expected 0/0", n_rel - nr, n_press - np);
        end
        checks++;
        if (unpressed_seen) begin
            errors++;
            $display("FAIL glitch_pressed_held: got pressed=0 seen expected always 1");
        end
        checks++;
        if (rpt_q.size() < 1 || rpt_q[0] != cg + 15) begin
            errors++;
            $display("FAIL glitch_repeat_restart: got %0d expected %0d",
                     (rpt_q.size() > 0) ? rpt_q[0] : -1, cg + 15);
        end
        botao = 1'b1;
        tick(12);
        checks++;
        if (n_rel - nr != 1 || press_count !== 8'd2) begin
            errors++;
            $display("FAIL glitch_final: got rel=%0d count=%0d expected 1/2", n_rel - nr, press_count);
        end
    endtask

    task automatic test_reset_mid_hold();
        int cr, np, nr;
        botao = 1'b0;
        tick(20);
        np = n_press; nr = n_rel;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pressed, press_pulse, release_pulse, repeat_pulse, press_count} !== 12'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {pressed, press_pulse, release_pulse, repeat_pulse, press_count});
        end
        tick(3);
        reset_n = 1'b1;
        cr = cyc;
        tick(10);
        checks++;
        if (n_press - np != 1 || t_press != cr + 7) begin
            errors++;
            $display("FAIL reset_repress: got n=%0d at %0d expected n=1 at %0d", n_press - np, t_press, cr + 7);
        end
        checks++;
        if (n_rel != nr || press_count !== 8'd1) begin
            errors++;
            $display("FAIL reset_no_release: got rel=%0d count=%0d expected 0/1", n_rel - nr, press_count);
        end
        botao = 1'b1;
        tick(12);
    endtask

    task automatic test_wrap();
        int np, nr;
        reset_n = 1'b0; tick(2);
        reset_n = 1'b1; tick(2);
        np = n_press; nr = n_rel;
        for (int i = 0; i < 256; i++) begin
            botao = 1'b0; tick(10);
            botao = 1'b1; tick(10);
            if (i == 254) begin
                checks++;
                if (press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: got %0d expected 255", press_count);
                end
            end
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 0", press_count);
        end
        checks++;
        if (n_press - np != 256 || n_rel - nr != 256) begin
            errors++;
            $display("FAIL wrap_pulses: got press=%0d rel=%0d expected 256/256", n_press - np, n_rel - nr);
        end
    endtask

    task automatic test_no_repeat();
        int np, nr, nt;
        np = n_press2; nr = n_rel2; nt = n_rpt2;
        botao2 = 1'b0;
        tick(50);
        checks++;
        if (pressed2 !== 1'b1) begin
            errors++;
            $display("FAIL norpt_pressed: got %b expected 1", pressed2);
        end
        botao2 = 1'b1;
        tick(12);
        checks++;
        if (n_press2 - np != 1 || n_rpt2 != nt) begin
            errors++;
            $display("FAIL norpt_pulses: got press=%0d rpt=%0d expected 1/0", n_press2 - np, n_rpt2 - nt);
        end
        checks++;
        if (n_rel2 - nr != 1 || press_count2 !== 8'd1) begin
            errors++;
            $display("FAIL norpt_release: got rel=%0d count=%0d expected 1/1", n_rel2 - nr, press_count2);
        end
    endtask

    initial begin
        test_reset();
        test_bounce_press();
        test_clean_press();
        test_bounce_release();
        test_reset_mid_hold();
        test_wrap();
        test_no_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
